// File: rtl/ecg_decomp_core_if.sv
// rtl/ecg_decomp_core_if.sv - codeword and sample handshake bundle for ecg_decomp_core
interface ecg_decomp_core_if #(
  parameter int SW = 16
);
  logic                 cw_valid;
  logic                 cw_ready;
  logic [1:0]           cw_type;
  logic [11:0]          cw_data;
  logic                 sample_valid;
  logic                 sample_ready;
  logic signed [SW-1:0] sample_out;
  logic                 blk_last;

  modport master (
    output cw_valid, cw_type, cw_data, sample_ready,
    input  cw_ready, sample_valid, sample_out, blk_last
  );

  modport slave (
    input  cw_valid, cw_type, cw_data, sample_ready,
    output cw_ready, sample_valid, sample_out, blk_last
  );
endinterface

// File: rtl/ecg_decomp_core.sv
// rtl/ecg_decomp_core.sv - run/Rice codeword decoder with delta reconstruction
// Optional ECG_DEC_SAT_EN: clamp reconstructed samples and raise sticky sat_flag.
module ecg_decomp_core #(
  parameter int SW  = 16,
  parameter int BLK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                sat_flag,
  ecg_decomp_core_if.slave    bus
);
  localparam int BW = (BLK > 1) ? $clog2(BLK) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, RUN} state_t;

  state_t               state, state_nxt;
  logic signed [SW-1:0] predictor, pred_eff, result, sample_hold;
  logic [BW-1:0]        blk_cnt;
  logic [7:0]           run_cnt;
  logic                 accept, out_hs, is_run, run_nz;
  logic                 sgn;
  logic [10:0]          mag;
  logic signed [SW:0]   mag_ext, delta, sum;

  assign accept   = bus.cw_valid && bus.cw_ready;
  assign out_hs   = bus.sample_valid && bus.sample_ready;
  assign is_run   = (bus.cw_type == 2'd0);
  assign run_nz   = |bus.cw_data[7:0];
  assign pred_eff = start ? '0 : predictor;

  // Magnitude is simply the low k+6 bits; the sign sits just above them.
  always_comb begin
    sgn = 1'b0;
    mag = '0;
    case (bus.cw_type)
      2'd1: begin sgn = bus.cw_data[9];  mag = {2'b00, bus.cw_data[8:0]}; end
      2'd2: begin sgn = bus.cw_data[10]; mag = {1'b0, bus.cw_data[9:0]};  end
      2'd3: begin sgn = bus.cw_data[11]; mag = bus.cw_data[10:0];         end
      default: ;
    endcase
  end

  assign mag_ext = {{(SW-10){1'b0}}, mag};
  assign delta   = sgn ? -mag_ext : mag_ext;
  assign sum     = {pred_eff[SW-1], pred_eff} + delta;

`ifdef ECG_DEC_SAT_EN
  logic ovf;
  assign ovf    = sum[SW] ^ sum[SW-1];
  assign result = ovf ? (sum[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}})
                      : sum[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else        sat_flag <= (sat_flag && !start) || (accept && ovf);
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum[SW];
  assign result         = sum[SW-1:0];
  assign sat_flag       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, EMIT: begin
        if (state == EMIT && start)
          state_nxt = IDLE;
        else if (accept)
          state_nxt = is_run ? (run_nz ? RUN : IDLE) : EMIT;
        else if (state == EMIT && bus.sample_ready)
          state_nxt = IDLE;
      end
      RUN: begin
        if (start)
          state_nxt = IDLE;
        else if (out_hs && run_cnt == 8'd1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cw_ready     = rst_n && ((state == IDLE) ||
                                 (state == EMIT && bus.sample_ready && !start));
    bus.sample_valid = (state != IDLE);
    bus.blk_last     = (state != IDLE) && (blk_cnt == BW'(BLK-1));
    bus.sample_out   = sample_hold;
  end

  // An accepted codeword overrides the start clear so it decodes against zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predictor   <= '0;
      sample_hold <= '0;
      blk_cnt     <= '0;
      run_cnt     <= '0;
    end else begin
      if (start) begin
        predictor <= '0;
        blk_cnt   <= '0;
        run_cnt   <= '0;
      end else begin
        if (out_hs)
          blk_cnt <= blk_cnt + 1'b1;
        if (state == RUN && out_hs)
          run_cnt <= run_cnt - 1'b1;
      end
      if (accept) begin
        predictor   <= result;
        sample_hold <= result;
        run_cnt     <= is_run ? bus.cw_data[7:0] : 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_ecg_decomp_core.sv
// tb/tb_ecg_decomp_core.sv - directed scoreboard bench for ecg_decomp_core
module tb_ecg_decomp_core;
  localparam int SW  = 16;
  localparam int BLK = 8;

  typedef struct packed {
    logic signed [SW-1:0] v;
    logic                 last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sat_flag;

  ecg_decomp_core_if #(.SW(SW)) bus ();

  ecg_decomp_core #(.SW(SW), .BLK(BLK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sat_flag (sat_flag),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t                 sb[$];
  int                   n_pass = 0;
  int                   n_total = 0;
  logic signed [SW-1:0] tb_pred = '0;
  int                   tb_blk = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic signed [SW-1:0] model_add(input logic signed [SW-1:0] p,
                                                     input int dlt);
    int s;
    s = int'(p) + dlt;
`ifdef ECG_DEC_SAT_EN
    if (s > 2**(SW-1) - 1) s = 2**(SW-1) - 1;
    else if (s < -(2**(SW-1))) s = -(2**(SW-1));
`endif
    return s[SW-1:0];
  endfunction

  task automatic model_reset();
    sb.delete();
    tb_pred = '0;
    tb_blk  = 0;
  endtask

  task automatic push(input logic signed [SW-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{v: v, last: (tb_blk == BLK-1)});
      tb_blk = (tb_blk + 1) % BLK;
    end
  endtask

  // Entered and left on a falling edge; expectations are queued at acceptance.
  task automatic send_cw(input logic [1:0] t, input logic [11:0] d,
                         input logic signed [SW-1:0] v, input int n);
    bit ok;
    ok = 1'b0;
    bus.cw_type  = t;
    bus.cw_data  = d;
    bus.cw_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cw_ready) begin
        ok = 1'b1;
        push(v, n);
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
    end
    bus.cw_valid = 1'b0;
    @(negedge clk);
    check("cw_accepted", 32'(ok), 1);
  endtask

  task automatic send_rice(input int k, input bit sgn, input int q, input int r);
    int mag;
    logic [11:0] d;
    mag = (q << k) | r;
    d   = 12'((int'(sgn) << (k + 6)) | (q << k) | r);
    tb_pred = model_add(tb_pred, sgn ? -mag : mag);
    send_cw(2'(k - 2), d, tb_pred, 1);
  endtask

  task automatic send_run(input int n);
    send_cw(2'd0, 12'(n), tb_pred, n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !start && bus.sample_valid && bus.sample_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sample_out", bus.sample_out, e.v);
        check("blk_last", 32'(bus.blk_last), 32'(e.last));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.cw_valid     = 1'b0;
    bus.cw_type      = 2'd0;
    bus.cw_data      = 12'd0;
    bus.sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.sample_valid), 0);
    check("rst_out", bus.sample_out, 0);
    check("rst_last", 32'(bus.blk_last), 0);
    check("rst_sat", 32'(sat_flag), 0);
    check("rst_ready", 32'(bus.cw_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.cw_ready), 1);

    // two Rice codewords from reset
    send_rice(3, 1'b0, 2, 5);
    check("lat1_valid_a", 32'(bus.sample_valid), 1);
    check("first_21", bus.sample_out, 21);
    send_rice(4, 1'b1, 1, 0);
    check("lat1_valid_b", 32'(bus.sample_valid), 1);
    check("second_5", bus.sample_out, 5);
    @(negedge clk);
    check("idle_after_emit", 32'(bus.sample_valid), 0);

    send_run(0);
    check("run0_silent", 32'(bus.sample_valid), 0);

    // run of 3 with a two-cycle stall after the first sample
    send_run(3);
    check("run_first_5", bus.sample_out, 5);
    check("run_cw_ready0", 32'(bus.cw_ready), 0);
    @(posedge clk);
    #1 bus.sample_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.sample_valid), 1);
      check("stall_out", bus.sample_out, 5);
      check("stall_cw_ready", 32'(bus.cw_ready), 0);
    end
    @(posedge clk);
    #1 bus.sample_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.sample_valid) break;
      check("run_cw_ready", 32'(bus.cw_ready), 0);
    end
    check("run_done", 32'(bus.sample_valid), 0);
    check("run_exact3", sb.size(), 0);

    // nine back-to-back Rice samples across a block boundary
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      send_rice(3, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 7));
      check("b2b_valid", 32'(bus.sample_valid), 1);
      check("b2b_last", 32'(bus.blk_last), (i == 7) ? 1 : 0);
    end
    @(negedge clk);

    // accumulate to 32760 then add 21
    pulse_start();
    repeat (16) send_rice(5, 1'b0, 63, 31);
    send_rice(3, 1'b0, 1, 0);
    check("pred_32760", bus.sample_out, 32760);
    send_rice(3, 1'b0, 2, 5);
`ifdef ECG_DEC_SAT_EN
    check("sat_out", bus.sample_out, 32767);
    check("sat_flag_set", 32'(sat_flag), 1);
`else
    check("wrap_out", bus.sample_out, -32755);
    check("sat_flag_tied", 32'(sat_flag), 0);
`endif
    @(negedge clk);
    pulse_start();
    check("sat_cleared", 32'(sat_flag), 0);

    // start aborts a run of 10 after four samples
    send_rice(4, 1'b0, 6, 4);
    send_run(10);
    repeat (4) @(posedge clk);
    #1;
    bus.sample_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.sample_ready = 1'b1;
    @(negedge clk);
    check("abort_valid0", 32'(bus.sample_valid), 0);
    check("abort_left6", sb.size(), 6);
    model_reset();
    send_rice(3, 1'b0, 0, 3);
    check("after_abort_3", bus.sample_out, 3);
    check("after_abort_last", 32'(bus.blk_last), 0);
    for (int i = 1; i < 8; i++) begin
      send_rice(3, 1'b0, 0, 0);
      check("restart_last", 32'(bus.blk_last), (i == 7) ? 1 : 0);
    end
    @(negedge clk);

    // asynchronous reset in the middle of a run
    send_run(20);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.sample_valid), 0);
    check("mid_rst_out", bus.sample_out, 0);
    check("mid_rst_last", 32'(bus.blk_last), 0);
    check("mid_rst_sat", 32'(sat_flag), 0);
    check("mid_rst_ready", 32'(bus.cw_ready), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.cw_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check("post_rst_silent", 32'(bus.sample_valid), 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
